// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                                    |
// | Purpose  : Drains a byte FIFO and serialises each byte as an 8-bit frame:  |
// |            start, 8 data bits LSB first, optional even parity, stop.       |
// | Option   : define UART_TX_PARITY_EN to insert the even-parity bit.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_uart_tx #(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              tx_en,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]         c_LAST_BIT  = 3'd7;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd6
  } state_t;
`endif

  state_t              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_baud, w_baud_nxt;
  logic [2:0]          r_bit_idx, w_bit_idx_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_tx, w_tx_nxt;
  logic                r_busy;
  logic                r_tx_done;
  logic                w_baud_end;

`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  assign w_baud_end = (r_baud == c_BAUD_LAST);

  // Baud counter defaults to zero so every state entry restarts the bit period.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = '0;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty && tx_en) w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_START;
        w_shift_nxt = fifo_data;
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) w_state_nxt = S_STOP;
        else            w_baud_nxt  = r_baud + 1'b1;
      end
`endif
      S_STOP: begin
        if (w_baud_end) w_state_nxt = S_IDLE;
        else            w_baud_nxt  = r_baud + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is derived from the next state so tx changes on the same edge as the state.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_parity;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_tx_done <= (w_state_nxt == S_STOP) && (w_baud_nxt == c_BAUD_LAST);
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 r_parity <= 1'b0;
    else if (r_state == S_LOAD) r_parity <= ^fifo_data;
  end
`endif

  assign fifo_rd = (r_state == S_FETCH);
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

endmodule
`default_nettype wire
